// File: rtl/vend_ctrl_param.sv
// Parametrised coin vending controller: credit accumulation, single vend, greedy change.
// Optional cancel/refund enabled by defining VEND_CANCEL_EN.
module vend_ctrl_param #(
  parameter int unsigned CRED_W     = 5,
  parameter int unsigned V_LO       = 1,
  parameter int unsigned V_MID      = 5,
  parameter int unsigned V_HI       = 10,
  parameter int unsigned PRICE      = 3,
  parameter int unsigned MAX_CREDIT = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coin_lo,
  input  logic              coin_mid,
  input  logic              coin_hi,
  input  logic              cancel,
  output logic              vend,
  output logic              change_mid,
  output logic              change_lo,
  output logic              coin_reject,
  output logic              busy,
  output logic [CRED_W-1:0] credit
);

  localparam int unsigned SUM_W = CRED_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic              reject_d;
  logic              vend_d, change_mid_d, change_lo_d, busy_d;

  logic [1:0]        n_coins;
  logic              any_coin;
  logic [SUM_W-1:0]  coin_val;
  logic [SUM_W-1:0]  sum;
  logic              cancel_req;

`ifdef VEND_CANCEL_EN
  assign cancel_req = cancel;
`else
  logic unused_cancel;
  assign cancel_req    = 1'b0;
  assign unused_cancel = cancel;
`endif

  // Coin decode; the sum is one bit wider than credit so it never wraps.
  always_comb begin
    n_coins  = 2'(coin_lo) + 2'(coin_mid) + 2'(coin_hi);
    any_coin = (n_coins != 2'd0);
    coin_val = '0;
    if (coin_hi) begin
      coin_val = SUM_W'(V_HI);
    end else if (coin_mid) begin
      coin_val = SUM_W'(V_MID);
    end else if (coin_lo) begin
      coin_val = SUM_W'(V_LO);
    end
    sum = SUM_W'(credit_q) + coin_val;
  end

  // Next-state and credit update
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (cancel_req && (state_q == S_COLLECT)) begin
          // Full refund: pay the held credit back as change; a same-edge coin loses.
          state_d  = S_CHANGE;
          reject_d = any_coin;
        end else if (any_coin) begin
          if ((n_coins != 2'd1) || (sum > SUM_W'(MAX_CREDIT))) begin
            reject_d = 1'b1;
          end else begin
            credit_d = CRED_W'(sum);
            state_d  = (sum >= SUM_W'(PRICE)) ? S_VEND : S_COLLECT;
          end
        end
      end
      S_VEND: begin
        reject_d = any_coin;
        credit_d = credit_q - CRED_W'(PRICE);
        state_d  = (credit_d != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        reject_d = any_coin;
        if (credit_q >= CRED_W'(V_MID)) begin
          credit_d = credit_q - CRED_W'(V_MID);
        end else if (credit_q != '0) begin
          credit_d = credit_q - CRED_W'(V_LO);
        end
        state_d = (credit_d == '0) ? S_IDLE : S_CHANGE;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Output flags describe the state being entered, so they line up with it after the edge.
  always_comb begin
    vend_d       = (state_d == S_VEND);
    busy_d       = (state_d == S_VEND) || (state_d == S_CHANGE);
    change_mid_d = (state_d == S_CHANGE) && (credit_d >= CRED_W'(V_MID));
    change_lo_d  = (state_d == S_CHANGE) && (credit_d < CRED_W'(V_MID));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      vend        <= 1'b0;
      change_mid  <= 1'b0;
      change_lo   <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      vend        <= vend_d;
      change_mid  <= change_mid_d;
      change_lo   <= change_lo_d;
      coin_reject <= reject_d;
      busy        <= busy_d;
    end
  end

  assign credit = credit_q;

  a_change_onehot: assert property (@(posedge clk) disable iff (reset)
    !(change_mid && change_lo));
  a_vend_alone: assert property (@(posedge clk) disable iff (reset)
    !(vend && (change_mid || change_lo)));

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench for vend_ctrl_param: vector table through a scoreboard queue,
// plus whole-sale latency/payout sequences. Default instance and a PRICE=18 instance.
module tb_vend_ctrl_param;

  typedef struct packed {
    logic rst;
    logic lo;
    logic mid;
    logic hi;
    logic can;
  } in_t;

  typedef struct packed {
    logic       vend;
    logic       cmid;
    logic       clo;
    logic       rej;
    logic       busy;
    logic [4:0] credit;
  } out_t;

  typedef struct packed {
    logic sel;
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, coin_lo, coin_mid, coin_hi, cancel;
  logic vend0, cm0, cl0, rej0, busy0;
  logic vend1, cm1, cl1, rej1, busy1;
  logic [4:0] cr0, cr1;
  out_t act0, act1;

  assign act0 = {vend0, cm0, cl0, rej0, busy0, cr0};
  assign act1 = {vend1, cm1, cl1, rej1, busy1, cr1};

  vend_ctrl_param dut (
    .clk(clk), .reset(reset), .coin_lo(coin_lo), .coin_mid(coin_mid),
    .coin_hi(coin_hi), .cancel(cancel), .vend(vend0), .change_mid(cm0),
    .change_lo(cl0), .coin_reject(rej0), .busy(busy0), .credit(cr0)
  );

  vend_ctrl_param #(.PRICE(18)) dut18 (
    .clk(clk), .reset(reset), .coin_lo(coin_lo), .coin_mid(coin_mid),
    .coin_hi(coin_hi), .cancel(cancel), .vend(vend1), .change_mid(cm1),
    .change_lo(cl1), .coin_reject(rej1), .busy(busy1), .credit(cr1)
  );

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];
  vec_t sb_q[$];

  function automatic vec_t mk(input logic sel, input logic rst, input logic lo,
                              input logic mid, input logic hi, input logic can,
                              input logic vd, input logic cm, input logic cl,
                              input logic rj, input logic bs, input int cr);
    vec_t v;
    v.sel        = sel;
    v.in         = '{rst, lo, mid, hi, can};
    v.exp.vend   = vd;
    v.exp.cmid   = cm;
    v.exp.clo    = cl;
    v.exp.rej    = rj;
    v.exp.busy   = bs;
    v.exp.credit = 5'(cr);
    return v;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got vend=%0b cmid=%0b clo=%0b rej=%0b busy=%0b credit=%0d, want vend=%0b cmid=%0b clo=%0b rej=%0b busy=%0b credit=%0d",
               name, act.vend, act.cmid, act.clo, act.rej, act.busy, act.credit,
               exp.vend, exp.cmid, exp.clo, exp.rej, exp.busy, exp.credit);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive one edge worth of inputs, queue the expectation, compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    reset    = v.in.rst;
    coin_lo  = v.in.lo;
    coin_mid = v.in.mid;
    coin_hi  = v.in.hi;
    cancel   = v.in.can;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.sel) check_out($sformatf("p18_vec%0d", idx), act1, e.exp);
    else       check_out($sformatf("vec%0d", idx), act0, e.exp);
  endtask

  task automatic clear_inputs();
    reset = 1'b0; coin_lo = 1'b0; coin_mid = 1'b0; coin_hi = 1'b0; cancel = 1'b0;
  endtask

  // n_lo low coins then a high coin; measure the whole sale on the default instance.
  task automatic run_sale(input int n_lo, input int exp_busy, input int exp_paid);
    int  n_busy, n_vend, paid;
    logic done;
    n_busy = 0; n_vend = 0; paid = 0; done = 1'b0;
    clear_inputs();
    for (int i = 0; i < n_lo; i++) begin
      coin_lo = 1'b1;
      @(posedge clk); #1;
      coin_lo = 1'b0;
    end
    coin_hi = 1'b1;
    @(posedge clk); #1;
    coin_hi = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy0) begin
        done = 1'b1;
        break;
      end
      n_busy++;
      n_vend += int'(vend0);
      paid   += cm0 ? 5 : (cl0 ? 1 : 0);
      @(posedge clk); #1;
    end
    check_int($sformatf("sale%0d_done", n_lo), int'(done), 1);
    check_int($sformatf("sale%0d_busy_cycles", n_lo), n_busy, exp_busy);
    check_int($sformatf("sale%0d_vends", n_lo), n_vend, 1);
    check_int($sformatf("sale%0d_paid", n_lo), paid, exp_paid);
    check_int($sformatf("sale%0d_credit", n_lo), int'(cr0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;

    // sel rst lo mid hi can | vend cmid clo rej busy credit
    vecs.push_back(mk(0, 1,0,0,0,0, 0,0,0,0,0, 0));
    vecs.push_back(mk(0, 0,1,0,0,0, 0,0,0,0,0, 1));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 1));
    vecs.push_back(mk(0, 0,1,0,0,0, 0,0,0,0,0, 2));
    vecs.push_back(mk(0, 0,1,0,0,0, 1,0,0,0,1, 3));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
    vecs.push_back(mk(0, 0,0,0,1,0, 1,0,0,0,1, 10));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,1,0,0,1, 7));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 2));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 1));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
    vecs.push_back(mk(0, 0,1,1,0,0, 0,0,0,1,0, 0));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
    vecs.push_back(mk(0, 0,1,1,1,0, 0,0,0,1,0, 0));
    vecs.push_back(mk(0, 0,0,1,1,0, 0,0,0,1,0, 0));
    vecs.push_back(mk(0, 0,0,0,1,0, 1,0,0,0,1, 10));
    vecs.push_back(mk(0, 0,1,0,0,0, 0,1,0,1,1, 7));
    vecs.push_back(mk(0, 0,1,0,0,0, 0,0,1,1,1, 2));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 1));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
    vecs.push_back(mk(0, 0,0,1,0,0, 1,0,0,0,1, 5));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 2));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 1));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
    // reset during change discards the rest
    vecs.push_back(mk(0, 0,0,0,1,0, 1,0,0,0,1, 10));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,1,0,0,1, 7));
    vecs.push_back(mk(0, 1,1,0,0,0, 0,0,0,0,0, 0));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
    // cancel outside COLLECT has no effect
    vecs.push_back(mk(0, 0,0,0,0,1, 0,0,0,0,0, 0));
    vecs.push_back(mk(0, 0,0,0,1,0, 1,0,0,0,1, 10));
    vecs.push_back(mk(0, 0,0,0,0,1, 0,1,0,0,1, 7));
    vecs.push_back(mk(0, 0,0,0,0,1, 0,0,1,0,1, 2));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 1));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
    // cancel in COLLECT
    vecs.push_back(mk(0, 0,1,0,0,0, 0,0,0,0,0, 1));
    vecs.push_back(mk(0, 0,1,0,0,0, 0,0,0,0,0, 2));
`ifdef VEND_CANCEL_EN
    vecs.push_back(mk(0, 0,0,0,0,1, 0,0,1,0,1, 2));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 1));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
`else
    vecs.push_back(mk(0, 0,0,0,0,1, 0,0,0,0,0, 2));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 2));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 2));
    vecs.push_back(mk(0, 1,0,0,0,0, 0,0,0,0,0, 0));
`endif
    // cancel with a coin on the same edge
    vecs.push_back(mk(0, 0,1,0,0,0, 0,0,0,0,0, 1));
    vecs.push_back(mk(0, 0,1,0,0,0, 0,0,0,0,0, 2));
`ifdef VEND_CANCEL_EN
    vecs.push_back(mk(0, 0,0,1,0,1, 0,0,1,1,1, 2));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 1));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
`else
    vecs.push_back(mk(0, 0,0,1,0,1, 1,0,0,0,1, 7));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 4));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 3));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 2));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,1,0,1, 1));
    vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0));
`endif
    // PRICE=18 instance: overflow rejection and exact MAX_CREDIT
    vecs.push_back(mk(1, 1,0,0,0,0, 0,0,0,0,0, 0));
    vecs.push_back(mk(1, 0,0,0,1,0, 0,0,0,0,0, 10));
    vecs.push_back(mk(1, 0,0,1,0,0, 0,0,0,0,0, 15));
    vecs.push_back(mk(1, 0,0,0,1,0, 0,0,0,1,0, 15));
    vecs.push_back(mk(1, 0,0,1,0,0, 1,0,0,0,1, 20));
    vecs.push_back(mk(1, 0,0,0,0,0, 0,0,1,0,1, 2));
    vecs.push_back(mk(1, 0,0,0,0,0, 0,0,1,0,1, 1));
    vecs.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0));
    // return the default instance to a known state
    vecs.push_back(mk(0, 1,0,0,0,0, 0,0,0,0,0, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    run_sale(0, 4, 7);
    run_sale(1, 5, 8);
    run_sale(2, 6, 9);

    check_int("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
